// File: rtl/imem_pkg.sv
// imem_pkg: shared widths, FSM state encoding and line-buffer payload for the
// I-cache line-refill responder (imem_line_responder and its sub-modules).
package imem_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned CLSIZE         = 256;
    localparam int unsigned WORDS_PER_LINE = CLSIZE / XLEN;
    localparam int unsigned WORD_BYTES     = XLEN / 8;
    localparam int unsigned LINE_OFS_BITS  = $clog2(CLSIZE / 8);
    localparam int unsigned SLOT_W         = $clog2(WORDS_PER_LINE);
    localparam int unsigned CNT_W          = SLOT_W + 1;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [CLSIZE-1:0] line_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2,
        HIT   = 2'd3
    } rsp_state_e;

    // One-entry line buffer: tag is the line-aligned base address.
    typedef struct packed {
        logic  valid;
        word_t tag;
        line_t line;
    } line_buf_t;

    // Clear the byte-offset-within-line bits of an address.
    function automatic word_t line_base(input word_t addr);
        word_t mask;
        mask = ~((word_t'(1) << LINE_OFS_BITS) - word_t'(1));
        return addr & mask;
    endfunction

endpackage

// File: rtl/imem_line_responder_if.sv
// imem_line_responder_if: word-wide pipelined read bus between the line
// responder (master) and the memory arbiter/TCM (slave).
//   b_req    master->slave  word read request
//   b_addr   master->slave  word address
//   b_gnt    slave->master  request accepted this cycle
//   b_rvalid slave->master  read data valid, returned in issue order
//   b_rdata  slave->master  read data
interface imem_line_responder_if;
    import imem_pkg::*;

    logic  b_req;
    word_t b_addr;
    logic  b_gnt;
    logic  b_rvalid;
    word_t b_rdata;

    modport master (
        output b_req,
        output b_addr,
        input  b_gnt,
        input  b_rvalid,
        input  b_rdata
    );

    modport slave (
        input  b_req,
        input  b_addr,
        output b_gnt,
        output b_rvalid,
        output b_rdata
    );

endinterface

// File: rtl/imem_line_asm.sv
// imem_line_asm: counts returned words and assembles them into a line register.
// Word slot 0 lands in the top XLEN bits, the last slot in [XLEN-1:0].
//   clk_i, rst_i  clock, synchronous active-high reset
//   start_i       clear counter and line (new fetch)
//   wr_i          a returned word is accepted this cycle
//   wdata_i       returned word
//   cnt_o         words returned so far (registered)
//   cnt_nxt_c     value cnt_o takes after this edge (combinational)
//   line_o        assembled line (registered)
module imem_line_asm
    import imem_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  start_i,
    input  logic  wr_i,
    input  word_t wdata_i,
    output cnt_t  cnt_o,
    output cnt_t  cnt_nxt_c,
    output line_t line_o
);

    cnt_t  cnt_q, cnt_d;
    line_t line_q, line_d;

    // Slot write; words beyond a full line are dropped rather than wrapping.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (start_i) begin
            cnt_d  = '0;
            line_d = '0;
        end else if (wr_i && (cnt_q < cnt_t'(WORDS_PER_LINE))) begin
            cnt_d = cnt_q + cnt_t'(1);
            for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
                if (cnt_q == cnt_t'(k)) begin
                    line_d[CLSIZE-1-k*XLEN -: XLEN] = wdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_c = cnt_d;
    assign line_o    = line_q;

endmodule

// File: rtl/imem_line_responder.sv
// imem_line_responder: memory-side responder for the I-cache line-refill port.
// Takes a line read request, fetches WORDS_PER_LINE words over the pipelined
// word bus with at most MAX_OUTST reads in flight, and returns the assembled
// line with a one-cycle c_ready_o pulse.
// Optional feature: define IMEM_LINE_BUF_EN for a one-entry line buffer that
// answers repeat requests without bus traffic (flush_i invalidates it);
// without the macro every request fetches and flush_i is ignored.
//   clk_i, rst_i  clock, synchronous active-high reset
//   c_strobe_i    line request (held until c_ready_o), c_addr_i address
//   c_ready_o     one-cycle pulse, c_data_o holds the line (word 0 on top)
//   flush_i       invalidate line buffer
//   bus           word read bus, master side
module imem_line_responder
    import imem_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  c_strobe_i,
    input  word_t c_addr_i,
    output logic  c_ready_o,
    output line_t c_data_o,
    input  logic  flush_i,
    imem_line_responder_if.master bus
);

    rsp_state_e state_q, state_d;
    cnt_t       issued_q, issued_d;
    word_t      base_q, base_d;
    logic       req_q, req_d;
    word_t      addr_q, addr_d;
    logic       ready_q, ready_d;
    line_t      data_q, data_d;

    logic  start_c;
    logic  fill_c;
    logic  issue_c;
    logic  rv_acc_c;
    cnt_t  returned_c;
    cnt_t  returned_nxt_c;
    cnt_t  outstanding_c;
    line_t asm_line_c;
    word_t req_base_c;
    logic  buf_hit_c;
    line_t buf_line_c;

    assign req_base_c    = line_base(c_addr_i);
    assign outstanding_c = issued_q - returned_c;
    assign issue_c       = req_q && bus.b_gnt;
    // Data with nothing in flight (or outside a fetch) is dropped.
    assign rv_acc_c      = (state_q == FETCH) && bus.b_rvalid && (outstanding_c != '0);

    imem_line_asm u_asm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_c),
        .wr_i      (rv_acc_c),
        .wdata_i   (bus.b_rdata),
        .cnt_o     (returned_c),
        .cnt_nxt_c (returned_nxt_c),
        .line_o    (asm_line_c)
    );

    // Next-state, issue control and registered output values.
    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        base_d   = base_q;
        ready_d  = 1'b0;
        data_d   = data_q;
        start_c  = 1'b0;
        fill_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (c_strobe_i) begin
                    base_d = req_base_c;
                    if (buf_hit_c) begin
                        state_d = HIT;
                        ready_d = 1'b1;
                        data_d  = buf_line_c;
                    end else begin
                        state_d  = FETCH;
                        issued_d = '0;
                        start_c  = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (issue_c) begin
                    issued_d = issued_q + cnt_t'(1);
                end
                // Last word goes straight into the output so ready and data align.
                if (rv_acc_c && (returned_c == cnt_t'(WORDS_PER_LINE - 1))) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    data_d  = {asm_line_c[CLSIZE-1:XLEN], bus.b_rdata};
                    fill_c  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            HIT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Request/address are registered, so they are computed from next-cycle counts.
        req_d  = (state_d == FETCH)
              && (issued_d < cnt_t'(WORDS_PER_LINE))
              && ((issued_d - returned_nxt_c) < cnt_t'(MAX_OUTST));
        addr_d = base_d + (word_t'(issued_d) * word_t'(WORD_BYTES));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            issued_q <= '0;
            base_q   <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            ready_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            base_q   <= base_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            ready_q  <= ready_d;
            data_q   <= data_d;
        end
    end

`ifdef IMEM_LINE_BUF_EN
    line_buf_t buf_q, buf_d;
    logic      nofill_q, nofill_d;

    // A flush seen while fetching keeps that line out of the buffer; flush wins over fill.
    always_comb begin
        buf_d    = buf_q;
        nofill_d = nofill_q;
        if (start_c) begin
            nofill_d = 1'b0;
        end else if (flush_i && (state_q == FETCH)) begin
            nofill_d = 1'b1;
        end
        if (fill_c && !nofill_q && !flush_i) begin
            buf_d.valid = 1'b1;
            buf_d.tag   = base_q;
            buf_d.line  = data_d;
        end
        if (flush_i) begin
            buf_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q    <= '0;
            nofill_q <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            nofill_q <= nofill_d;
        end
    end

    assign buf_hit_c  = buf_q.valid && (buf_q.tag == req_base_c) && !flush_i;
    assign buf_line_c = buf_q.line;

    logic unused_c;
    assign unused_c = ^asm_line_c[XLEN-1:0];
`else
    assign buf_hit_c  = 1'b0;
    assign buf_line_c = '0;

    logic unused_c;
    assign unused_c = ^{asm_line_c[XLEN-1:0], flush_i, fill_c};
`endif

    assign c_ready_o  = ready_q;
    assign c_data_o   = data_q;
    assign bus.b_req  = req_q;
    assign bus.b_addr = addr_q;

    // Read data must only arrive for a read that is in flight.
    rvalid_in_flight: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.b_rvalid |-> rv_acc_c);

endmodule

// File: tb/tb_imem_line_responder.sv
// tb_imem_line_responder: randomized bench for imem_line_responder with a
// queue-based memory/bus model and a line-level reference of expected results.
module tb_imem_line_responder;
    import imem_pkg::*;

    localparam int unsigned MAX_OUT = 2;

    logic  clk = 1'b0;
    logic  rst;
    logic  c_strobe;
    word_t c_addr;
    logic  c_ready;
    line_t c_data;
    logic  flush;

    always #5 clk = ~clk;

    imem_line_responder_if bus();

    imem_line_responder #(.MAX_OUTST(MAX_OUT)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .c_strobe_i (c_strobe),
        .c_addr_i   (c_addr),
        .c_ready_o  (c_ready),
        .c_data_o   (c_data),
        .flush_i    (flush),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    word_t pend[$];
    int    gnt_pct = 100;
    int    rv_pct = 100;
    int    stall_beat = -1;
    int    stall_left = 0;
    int    issues_in_req = 0;
    int    rv_in_req = 0;
    int    ready_cnt = 0;
    int    n_done = 0;
    word_t exp_issue_base = '0;
    int    exp_issue_n = 0;
    bit    prev_stall = 0;
    word_t prev_addr = '0;
    bit    mdl_valid = 0;
    word_t mdl_tag = '0;

    task automatic check(input string tag, input line_t got, input line_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic word_t mem_word(input word_t a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ (a >> 3);
    endfunction

    function automatic line_t exp_line(input word_t base);
        line_t l;
        l = '0;
        for (int k = 0; k < int'(WORDS_PER_LINE); k++) begin
            l[CLSIZE-1-k*XLEN -: XLEN] = mem_word(base + word_t'(4 * k));
        end
        return l;
    endfunction

    // Slave drive: random grant, in-order data from the pending queue.
    always @(negedge clk) begin
        bus.b_gnt = ($urandom_range(1, 100) <= gnt_pct);
        if (stall_beat >= 0 && issues_in_req == stall_beat && stall_left > 0 && bus.b_req) begin
            bus.b_gnt  = 1'b0;
            stall_left = stall_left - 1;
        end
        if (pend.size() > 0 && $urandom_range(1, 100) <= rv_pct) begin
            bus.b_rvalid = 1'b1;
            bus.b_rdata  = mem_word(pend[0]);
        end else begin
            bus.b_rvalid = 1'b0;
            bus.b_rdata  = $urandom;
        end
    end

    // Bus observation at the active edge: issue order, in-flight bound, stall stability.
    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            prev_stall = 0;
        end else begin
            if (c_ready) ready_cnt++;
            if (prev_stall) begin
                check("stall_req", line_t'(bus.b_req), line_t'(1));
                check("stall_addr", line_t'(bus.b_addr), line_t'(prev_addr));
            end
            if (bus.b_rvalid && pend.size() > 0) begin
                void'(pend.pop_front());
                rv_in_req++;
            end
            if (bus.b_req && bus.b_gnt) begin
                check("issue_addr", line_t'(bus.b_addr),
                      line_t'(exp_issue_base + word_t'(4 * exp_issue_n)));
                exp_issue_n++;
                issues_in_req++;
                pend.push_back(bus.b_addr);
                check("outstanding", line_t'(pend.size() <= int'(MAX_OUT)), line_t'(1));
            end
            prev_stall = bus.b_req && !bus.b_gnt;
            prev_addr  = bus.b_addr;
        end
    end

    // One cache request; entered and left on a negedge.
    task automatic do_req(input word_t addr, input int flush_at, input int rst_after_rv,
                          input bit chk_lat);
        word_t base;
        bit    hit;
        bit    got;
        bit    flushed;
        int    lat;
        base = addr & ~word_t'(CLSIZE / 8 - 1);
`ifdef IMEM_LINE_BUF_EN
        hit = mdl_valid && (mdl_tag == base);
`else
        hit = 0;
`endif
        exp_issue_base = base;
        exp_issue_n    = 0;
        issues_in_req  = 0;
        rv_in_req      = 0;
        c_strobe = 1'b1;
        c_addr   = addr;
        got      = 0;
        flushed  = 0;
        lat      = 0;
        while (!got && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            flush = 1'b0;
            if (c_ready) begin
                got = 1;
            end else if (rst_after_rv >= 0 && rv_in_req >= rst_after_rv) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("rst_ready", line_t'(c_ready), '0);
                check("rst_breq", line_t'(bus.b_req), '0);
                check("rst_data", c_data, '0);
                rst       = 1'b0;
                c_strobe  = 1'b0;
                mdl_valid = 0;
                return;
            end else if (lat == flush_at) begin
                flush   = 1'b1;
                flushed = 1;
            end
        end
        check("timeout", line_t'(got), line_t'(1));
        check("line", c_data, exp_line(base));
        check("issues", line_t'(issues_in_req), line_t'(hit ? 0 : int'(WORDS_PER_LINE)));
        if (chk_lat) check("latency", line_t'(lat), line_t'(hit ? 1 : 10));
        c_strobe = 1'b0;
        @(negedge clk);
        check("ready_pulse", line_t'(c_ready), '0);
        n_done++;
        if (flushed) begin
            mdl_valid = 0;
        end else if (!hit) begin
            mdl_valid = 1;
            mdl_tag   = base;
        end
    endtask

    word_t pool [4] = '{32'h0000_3000, 32'h0000_7000, 32'h0000_8FE0, 32'h0001_0040};

    initial begin
        rst          = 1'b1;
        c_strobe     = 1'b0;
        c_addr       = '0;
        flush        = 1'b0;
        bus.b_gnt    = 1'b0;
        bus.b_rvalid = 1'b0;
        bus.b_rdata  = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", line_t'(c_ready), '0);
        check("reset_breq", line_t'(bus.b_req), '0);
        check("reset_baddr", line_t'(bus.b_addr), '0);
        check("reset_data", c_data, '0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait single line fetch with unaligned address.
        do_req(32'h0000_1234, -1, -1, 1);

        // Grant stall on the fourth beat plus data gaps.
        rv_pct = 50; stall_beat = 3; stall_left = 3;
        do_req(32'h0000_0A48, -1, -1, 0);
        check("stall_used", line_t'(stall_left), '0);
        stall_beat = -1; rv_pct = 100;

        // Reset mid-fetch, then a clean fetch.
        do_req(32'h0000_5000, -1, 3, 0);
        do_req(32'h0000_2000, -1, -1, 1);

        // Repeat request to the same line.
        do_req(32'h0000_3000, -1, -1, 1);
        do_req(32'h0000_3010, -1, -1, 1);

        // Flush during fetch, then the same line again.
        do_req(32'h0000_4000, 4, -1, 0);
        do_req(32'h0000_4000, -1, -1, 1);

        // Back-to-back requests.
        do_req(32'h0000_0100, -1, -1, 1);
        do_req(32'h0000_5100, -1, -1, 1);

        // Randomized traffic over a small address pool.
        repeat (30) begin
            word_t a;
            int    fa;
            a = pool[$urandom_range(0, 3)] | word_t'($urandom_range(0, 31));
            gnt_pct = $urandom_range(40, 100);
            rv_pct  = $urandom_range(40, 100);
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
            do_req(a, fa, -1, 0);
            if ($urandom_range(0, 4) == 0) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                mdl_valid = 0;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("ready_count", line_t'(ready_cnt), line_t'(n_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
